// File: rtl/circulacion_pkg.sv
// Shared types and sizes for the lane-routing sequencing controller.
package circulacion_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned UMBRAL_W  = 3;

    typedef enum logic [2:0] {
        RESET   = 3'd0,
        INIT    = 3'd1,
        IDLE_ST = 3'd2,
        ACTIVE  = 3'd3,
        ERROR   = 3'd4
    } estado_t;

endpackage

// File: rtl/contador_inactividad.sv
// Quiet-cycle counter: measures how long ACTIVE has seen no lane traffic.
module contador_inactividad
    import circulacion_pkg::*;
#(
    parameter int unsigned IDLE_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic quiet,
    output logic done
);

    localparam logic [3:0] LAST = 4'(IDLE_WAIT - 1);

    logic [3:0] cnt_q, cnt_d;

    // Saturates at LAST so done stays asserted for as long as the lanes stay quiet.
    always_comb begin
        cnt_d = 4'd0;
        if (enable && quiet) begin
            cnt_d = (cnt_q == LAST) ? LAST : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = quiet && (cnt_q == LAST);

endmodule

// File: rtl/control_circulacion.sv
// Sequencing controller: drives the shared IDLE routing select, latches FIFO
// thresholds and records FIFO errors for the 4-lane PHY routing stage.
module control_circulacion
    import circulacion_pkg::*;
#(
    parameter int unsigned IDLE_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [UMBRAL_W-1:0]  umbral_alto_in,
    input  logic [UMBRAL_W-1:0]  umbral_bajo_in,
    input  logic [NUM_LANES-1:0] valid_in,
    input  logic [NUM_LANES-1:0] fifo_empty,
    input  logic [NUM_LANES-1:0] fifo_error,
    output logic                 IDLE,
    output logic [2:0]           estado,
    output logic [UMBRAL_W-1:0]  umbral_alto_out,
    output logic [UMBRAL_W-1:0]  umbral_bajo_out,
    output logic [NUM_LANES-1:0] error_out,
    output logic                 cfg_error
);

    estado_t                state_q, state_d;
    logic [UMBRAL_W-1:0]    alto_q, alto_d;
    logic [UMBRAL_W-1:0]    bajo_q, bajo_d;
    logic [NUM_LANES-1:0]   err_q, err_d;
    logic                   cfg_q, cfg_d;
    logic                   quiet;
    logic                   done;
    logic                   any_err;

    assign quiet   = (&fifo_empty) && !(|valid_in);
    assign any_err = |fifo_error;

    contador_inactividad #(
        .IDLE_WAIT (IDLE_WAIT)
    ) u_contador (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ACTIVE),
        .quiet  (quiet),
        .done   (done)
    );

    always_comb begin
        state_d = state_q;
        alto_d  = alto_q;
        bajo_d  = bajo_q;
        err_d   = err_q;
        cfg_d   = cfg_q;

        // A FIFO error pre-empts every other transition, including init.
        if (any_err && (state_q inside {INIT, IDLE_ST, ACTIVE})) begin
            state_d = ERROR;
            err_d   = err_q | fifo_error;
        end else begin
            case (state_q)
                RESET: state_d = INIT;
                INIT: begin
                    alto_d = umbral_alto_in;
                    bajo_d = umbral_bajo_in;
                    if (!init) begin
                        if (umbral_bajo_in > umbral_alto_in) begin
                            state_d = ERROR;
                            cfg_d   = 1'b1;
                        end else begin
                            state_d = IDLE_ST;
                        end
                    end
                end
                IDLE_ST: begin
                    if (init) begin
                        state_d = INIT;
                    end else if (!(&fifo_empty)) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (init) begin
                        state_d = INIT;
                    end else if (done) begin
                        state_d = IDLE_ST;
                    end
                end
                ERROR:   err_d   = err_q | fifo_error;
                default: state_d = RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET;
            alto_q  <= '0;
            bajo_q  <= '0;
            err_q   <= '0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alto_q  <= alto_d;
            bajo_q  <= bajo_d;
            err_q   <= err_d;
            cfg_q   <= cfg_d;
        end
    end

    assign IDLE            = (state_q == IDLE_ST);
    assign estado          = state_q;
    assign umbral_alto_out = alto_q;
    assign umbral_bajo_out = bajo_q;
    assign error_out       = err_q;
    assign cfg_error       = cfg_q;

endmodule

// File: tb/tb_control_circulacion.sv
// Self-checking bench for control_circulacion: per-cycle model comparison plus
// directed scenarios with literal expectations.
module tb_control_circulacion;

    localparam int IDLE_WAIT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [2:0] umbral_alto_in;
    logic [2:0] umbral_bajo_in;
    logic [3:0] valid_in;
    logic [3:0] fifo_empty;
    logic [3:0] fifo_error;
    logic       idle;
    logic [2:0] estado;
    logic [2:0] umbral_alto_out;
    logic [2:0] umbral_bajo_out;
    logic [3:0] error_out;
    logic       cfg_error;

    int tests = 0;
    int fails = 0;

    control_circulacion #(
        .IDLE_WAIT (IDLE_WAIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_alto_in  (umbral_alto_in),
        .umbral_bajo_in  (umbral_bajo_in),
        .valid_in        (valid_in),
        .fifo_empty      (fifo_empty),
        .fifo_error      (fifo_error),
        .IDLE            (idle),
        .estado          (estado),
        .umbral_alto_out (umbral_alto_out),
        .umbral_bajo_out (umbral_bajo_out),
        .error_out       (error_out),
        .cfg_error       (cfg_error)
    );

    always #5 clk = ~clk;

    // Behavioural model: state as a plain integer code, plus a run length of
    // consecutive quiet cycles seen while active.
    int         m_state;
    int         m_quiet_run;
    logic [2:0] m_alto, m_bajo;
    logic [3:0] m_err;
    logic       m_cfg;
    bit         model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_quiet_run = 0; m_alto = 0; m_bajo = 0; m_err = 0; m_cfg = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 4) begin
                m_err = m_err | fifo_error;
            end else if (fifo_error != 4'd0) begin
                m_err = m_err | fifo_error;
                m_state = 4;
                m_quiet_run = 0;
            end else if (m_state == 1) begin
                m_alto = umbral_alto_in;
                m_bajo = umbral_bajo_in;
                if (!init) begin
                    if (int'(umbral_bajo_in) > int'(umbral_alto_in)) begin
                        m_state = 4;
                        m_cfg = 1'b1;
                    end else begin
                        m_state = 2;
                    end
                end
            end else if (init) begin
                m_state = 1;
                m_quiet_run = 0;
            end else if (m_state == 2) begin
                if (fifo_empty != 4'hF) m_state = 3;
            end else begin
                if (fifo_empty == 4'hF && valid_in == 4'd0) begin
                    m_quiet_run++;
                    if (m_quiet_run >= IDLE_WAIT) begin
                        m_state = 2;
                        m_quiet_run = 0;
                    end
                end else begin
                    m_quiet_run = 0;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            cmp("model.estado", 32'(estado), 32'(m_state));
            cmp("model.IDLE", 32'(idle), 32'(m_state == 2));
            cmp("model.alto", 32'(umbral_alto_out), 32'(m_alto));
            cmp("model.bajo", 32'(umbral_bajo_out), 32'(m_bajo));
            cmp("model.error_out", 32'(error_out), 32'(m_err));
            cmp("model.cfg_error", 32'(cfg_error), 32'(m_cfg));
        end
    end

    // Advance one edge; literal checks run 2 time units after it, clear of the negedge compare.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; umbral_alto_in = 3'd0; umbral_bajo_in = 3'd0;
        valid_in = 4'd0; fifo_empty = 4'hF; fifo_error = 4'd0;

        // 1. Config load
        tick(2);
        cmp("reset.estado", 32'(estado), 32'd0);
        cmp("reset.IDLE", 32'(idle), 32'd0);
        reset = 1'b0; init = 1'b1; umbral_alto_in = 3'd6; umbral_bajo_in = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("load.estado_init", 32'(estado), 32'd1);
        end
        init = 1'b0;
        tick();
        cmp("load.estado_idle", 32'(estado), 32'd2);
        cmp("load.IDLE", 32'(idle), 32'd1);
        cmp("load.alto", 32'(umbral_alto_out), 32'd6);
        cmp("load.bajo", 32'(umbral_bajo_out), 32'd2);
        cmp("load.cfg_error", 32'(cfg_error), 32'd0);

        // 2. Activate and return after IDLE_WAIT quiet cycles
        fifo_empty = 4'b1101;
        tick();
        cmp("act.estado", 32'(estado), 32'd3);
        cmp("act.IDLE", 32'(idle), 32'd0);
        fifo_empty = 4'hF;
        tick(3);
        cmp("act.still_active", 32'(estado), 32'd3);
        tick();
        cmp("act.back_idle", 32'(estado), 32'd2);

        // 3. Counter clear on a valid pulse
        fifo_empty = 4'b1101;
        tick();
        fifo_empty = 4'hF;
        tick(3);
        valid_in = 4'b0010;
        tick();
        cmp("clr.active_after_valid", 32'(estado), 32'd3);
        valid_in = 4'd0;
        tick(3);
        cmp("clr.active_3_quiet", 32'(estado), 32'd3);
        tick();
        cmp("clr.back_idle", 32'(estado), 32'd2);

        // ACTIVE -> INIT on init, threshold re-load with bajo == alto accepted
        fifo_empty = 4'b0111;
        tick();
        fifo_empty = 4'hF; init = 1'b1; umbral_alto_in = 3'd3; umbral_bajo_in = 3'd3;
        tick();
        cmp("reinit.estado", 32'(estado), 32'd1);
        init = 1'b0;
        tick();
        cmp("reinit.idle_equal", 32'(estado), 32'd2);
        cmp("reinit.alto", 32'(umbral_alto_out), 32'd3);

        // 5. Error beats init in ACTIVE, error_out is sticky/accumulating
        fifo_empty = 4'b1101;
        tick();
        fifo_empty = 4'hF; fifo_error = 4'b0100; init = 1'b1;
        tick();
        cmp("err.estado", 32'(estado), 32'd4);
        cmp("err.error_out", 32'(error_out), 32'h4);
        fifo_error = 4'd0; init = 1'b0;
        tick();
        fifo_error = 4'b0001;
        tick();
        fifo_error = 4'd0;
        cmp("err.accum", 32'(error_out), 32'h5);
        tick();
        cmp("err.absorbing", 32'(estado), 32'd4);

        // 4. Bad configuration
        reset = 1'b1;
        tick();
        cmp("rst_err.estado", 32'(estado), 32'd0);
        cmp("rst_err.error_out", 32'(error_out), 32'd0);
        reset = 1'b0; init = 1'b1; umbral_alto_in = 3'd1; umbral_bajo_in = 3'd5;
        tick(2);
        init = 1'b0;
        tick();
        cmp("badcfg.estado", 32'(estado), 32'd4);
        cmp("badcfg.cfg_error", 32'(cfg_error), 32'd1);
        cmp("badcfg.IDLE", 32'(idle), 32'd0);
        init = 1'b1;
        tick(3);
        cmp("badcfg.stays", 32'(estado), 32'd4);
        init = 1'b0;

        // 6. Reset mid-ACTIVE
        reset = 1'b1;
        tick();
        reset = 1'b0; init = 1'b1; umbral_alto_in = 3'd7; umbral_bajo_in = 3'd4;
        tick();
        init = 1'b0;
        tick();
        fifo_empty = 4'b1110;
        tick();
        cmp("mid.active", 32'(estado), 32'd3);
        fifo_empty = 4'hF; reset = 1'b1;
        tick();
        cmp("mid.estado", 32'(estado), 32'd0);
        cmp("mid.IDLE", 32'(idle), 32'd0);
        cmp("mid.alto", 32'(umbral_alto_out), 32'd0);
        cmp("mid.bajo", 32'(umbral_bajo_out), 32'd0);
        cmp("mid.error_out", 32'(error_out), 32'd0);
        cmp("mid.cfg_error", 32'(cfg_error), 32'd0);
        reset = 1'b0;
        tick();
        cmp("mid.init", 32'(estado), 32'd1);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_circulacion.md
Name: control_circulacion

Overview:
Sequencing controller for the 4-lane PHY routing stage. It generates the single IDLE select that steers all lanes either to the flop/FIFO path (IDLE=1) or to the probe path (IDLE=0). It also latches the FIFO threshold configuration and flags FIFO errors. It sits between the top-level init/config inputs and the lane-routing demux, and observes lane valids and FIFO status.

Parameters:
NUM_LANES, 4, number of lanes; fixes the width of the per-lane vectors.
UMBRAL_W, 3, width of each FIFO threshold field.
IDLE_WAIT, 4, consecutive quiet cycles required before ACTIVE returns to IDLE; range 1..15.

Ports:
clk  in  1  single clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high.
init  in  1  request to (re)load the threshold configuration.
umbral_alto_in  in  UMBRAL_W  almost-full threshold, sampled in INIT.
umbral_bajo_in  in  UMBRAL_W  almost-empty threshold, sampled in INIT.
valid_in  in  NUM_LANES  lane valids entering the routing stage.
fifo_empty  in  NUM_LANES  per-lane FIFO empty flags.
fifo_error  in  NUM_LANES  per-lane FIFO overflow/underflow pulses.
IDLE  out  1  routing select; 1 selects the flop path, 0 selects the probe path.
estado  out  3  current state encoding.
umbral_alto_out  out  UMBRAL_W  latched almost-full threshold.
umbral_bajo_out  out  UMBRAL_W  latched almost-empty threshold.
error_out  out  NUM_LANES  sticky per-lane error record.
cfg_error  out  1  sticky flag: latched bajo > alto.

Behaviour:
- Reset is one clock, synchronous and active-high; the polarity and synchronicity are fixed.
- While reset=1, at each edge:
  - state goes to RESET.
  - umbral_*_out, error_out, cfg_error and the quiet counter all go to 0.
  - IDLE=0.
- State encodings: RESET=3'd0, INIT=3'd1, IDLE=3'd2, ACTIVE=3'd3, ERROR=3'd4. estado = state register.
- IDLE output is a Moore decode: IDLE=1 exactly when state==IDLE. There is no extra register stage, so it changes in the same cycle as estado.
- Transitions are evaluated on each edge with reset=0. Priority is top-down:
  1. Any fifo_error bit=1 in INIT, IDLE or ACTIVE: go to ERROR; error_out |= fifo_error. Error beats init.
  2. RESET: go to INIT unconditionally. This is the first edge after reset deassert.
  3. INIT:
     - Load umbral_alto_out and umbral_bajo_out from the inputs every cycle.
     - Stay in INIT while init=1.
     - On init=0, leave INIT using the values loaded on that same edge:
       - If umbral_bajo_in > umbral_alto_in: go to ERROR and set cfg_error=1.
       - Otherwise go to IDLE.
  4. IDLE:
     - If init=1: go to INIT.
     - Else if any fifo_empty bit=0: go to ACTIVE.
  5. ACTIVE:
     - If init=1: go to INIT.
     - Else if the quiet counter == IDLE_WAIT-1 and this cycle is quiet: go to IDLE.
  6. ERROR: absorbing. Only reset exits. error_out keeps OR-ing new fifo_error bits.
- Quiet counter (width 4):
  - A cycle is quiet when fifo_empty is all ones and valid_in is all zeros.
  - In ACTIVE, the counter increments on quiet cycles, saturating at IDLE_WAIT-1.
  - Any non-quiet cycle clears it to 0. Any state other than ACTIVE holds it at 0.
  - With IDLE_WAIT=1, ACTIVE returns to IDLE on the first quiet cycle.
- Thresholds:
  - Held constant outside INIT.
  - Re-entering INIT overwrites them.
  - cfg_error is sticky until reset.
- Reset mid-operation, in any state: all outputs reach their reset values at the edge where reset=1 is sampled. There is no partial update.

Decomposition:
- Package circulacion_pkg holds:
  - the state localparams RESET, INIT, IDLE_ST, ACTIVE, ERROR (3 bits);
  - NUM_LANES;
  - UMBRAL_W.
- Sub-module contador_inactividad holds the quiet counter.
  - Inputs: clk, reset, enable (state==ACTIVE), quiet.
  - Output: done, asserted when the counter == IDLE_WAIT-1 and quiet=1.
- The FSM and the config registers stay in the top module.

Test Plan:
1. Config load: reset 2 cycles, then init=1 with alto=6, bajo=2 for 3 cycles, then init=0 → estado 0→1 (×3)→2; IDLE=1; umbral_alto_out=6, umbral_bajo_out=2; cfg_error=0.
2. Activate and return: from IDLE, set fifo_empty=4'b1101 for 1 cycle, then all ones with valid_in=0 → ACTIVE on the next edge; IDLE=0; returns to IDLE exactly 4 quiet cycles later (IDLE_WAIT=4).
3. Counter clear: in ACTIVE, quiet for 3 cycles, then valid_in=4'b0010 for 1 cycle, then quiet → IDLE is reached only after 4 further quiet cycles.
4. Bad config: init with alto=1, bajo=5, then init=0 → ERROR (4); cfg_error=1; IDLE=0; estado stays 4 until reset.
5. Error vs init: in ACTIVE, fifo_error=4'b0100 and init=1 on the same cycle → ERROR; error_out=4'b0100; a later fifo_error=4'b0001 gives error_out=4'b0101.
6. Reset mid-ACTIVE: reset=1 for 1 cycle during ACTIVE → next edge estado=0; IDLE=0; thresholds=0; error_out=0; then INIT on the following edge.
